// File: rtl/elevator_request_scheduler.sv
// ============================================================================
// Module  : elevator_request_scheduler
// Brief   : SCAN call scheduler feeding the elevator FSM. It latches the call
//           buttons and picks the next target floor. Defining DOOR_DWELL_EN
//           adds a door-dwell hold after each served floor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_request_scheduler #(
    parameter int DWELL_CYCLES = 8,
    parameter int DWELL_W      = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [3:0] i_call,
    input  logic [1:0] i_current_floor,
    output logic [1:0] o_target_floor,
    output logic [3:0] o_pending,
    output logic       o_dir_up,
    output logic       o_arrived,
    output logic       o_busy
);

    // A counter that cannot reach DWELL_CYCLES-1 would never leave DWELL.
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > (1 << DWELL_W)) begin : g_bad_dwell
        $error("DWELL_W too narrow for DWELL_CYCLES");
    end

`ifdef DOOR_DWELL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVING = 2'd1, S_DWELL = 2'd2} state_t;
    localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DWELL_CYCLES - 1);
    logic [DWELL_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVING = 2'd1} state_t;
`endif

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] target_q, target_d;
    logic       dir_q, dir_d;
    logic       arrived_q, arrived_d;
    logic [3:0] clr;

    logic       up_v, dn_v, mid_v;
    logic [1:0] up_f, dn_f, mid_f;
    logic [1:0] sel_f;
    logic       sel_dir;

    // Nearest pending floor above / below the car, and the nearest pending
    // floor strictly between the car and its current target.
    always_comb begin
        up_v  = 1'b0;
        up_f  = 2'd0;
        dn_v  = 1'b0;
        dn_f  = 2'd0;
        mid_v = 1'b0;
        mid_f = 2'd0;
        for (int f = 3; f >= 0; f--) begin
            if (pending_q[f] && f > int'(i_current_floor)) begin
                up_v = 1'b1;
                up_f = 2'(f);
            end
            if (dir_q && pending_q[f] && f > int'(i_current_floor) && f < int'(target_q)) begin
                mid_v = 1'b1;
                mid_f = 2'(f);
            end
        end
        for (int f = 0; f <= 3; f++) begin
            if (pending_q[f] && f < int'(i_current_floor)) begin
                dn_v = 1'b1;
                dn_f = 2'(f);
            end
            if (!dir_q && pending_q[f] && f < int'(i_current_floor) && f > int'(target_q)) begin
                mid_v = 1'b1;
                mid_f = 2'(f);
            end
        end
    end

    // SCAN: keep the sweep while something lies ahead, otherwise reverse.
    always_comb begin
        sel_f   = target_q;
        sel_dir = dir_q;
        if (dir_q) begin
            if (up_v) begin
                sel_f = up_f;
            end else if (dn_v) begin
                sel_f   = dn_f;
                sel_dir = 1'b0;
            end
        end else begin
            if (dn_v) begin
                sel_f = dn_f;
            end else if (up_v) begin
                sel_f   = up_f;
                sel_dir = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        dir_d     = dir_q;
        arrived_d = 1'b0;
        clr       = 4'b0000;
`ifdef DOOR_DWELL_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pending_q[i_current_floor]) begin
                    clr[i_current_floor] = 1'b1;
                    arrived_d            = 1'b1;
`ifdef DOOR_DWELL_EN
                    state_d              = S_DWELL;
`endif
                end else if (pending_q != 4'b0000) begin
                    target_d = sel_f;
                    dir_d    = sel_dir;
                    state_d  = S_MOVING;
                end
            end
            S_MOVING: begin
                if (i_current_floor == target_q) begin
                    clr[target_q] = 1'b1;
                    arrived_d     = 1'b1;
`ifdef DOOR_DWELL_EN
                    state_d       = S_DWELL;
`else
                    state_d       = S_IDLE;
`endif
                end else if (mid_v) begin
                    target_d = mid_f;
                end
            end
`ifdef DOOR_DWELL_EN
            S_DWELL: begin
                // Doors are open: presses for this floor are already satisfied.
                clr[i_current_floor] = 1'b1;
                if (cnt_q == c_dwell_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pending_d = (pending_q | i_call) & ~clr;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pending_q <= 4'b0000;
            target_q  <= 2'd0;
            dir_q     <= 1'b1;
            arrived_q <= 1'b0;
`ifdef DOOR_DWELL_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            arrived_q <= arrived_d;
`ifdef DOOR_DWELL_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign o_target_floor = target_q;
    assign o_pending      = pending_q;
    assign o_dir_up       = dir_q;
    assign o_arrived      = arrived_q;
    assign o_busy         = (state_q != S_IDLE) || (pending_q != 4'b0000);

endmodule

`default_nettype wire
